// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue of {PC, instruction}
// pairs sitting between a 1-cycle-latency synchronous instruction memory and ID.
// Handshake: ID sees a valid head when Instruction_valid=1; the head is consumed
// on every cycle where Instruction_valid=1 and freeze=0, and held otherwise.
module if_prefetch_stage #(
    parameter int                     ADDRESS_LEN     = 32,
    parameter int                     INSTRUCTION_LEN = 32,
    parameter int                     DEPTH           = 4,
    parameter int                     PC_STEP         = 4,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC        = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         Branch_taken,
    input  logic [ADDRESS_LEN-1:0]       BranchAddr,
    output logic                         imem_req,
    output logic [ADDRESS_LEN-1:0]       imem_addr,
    input  logic [INSTRUCTION_LEN-1:0]   imem_rdata,
    output logic                         Instruction_valid,
    output logic [INSTRUCTION_LEN-1:0]   Instruction,
    output logic [ADDRESS_LEN-1:0]       PC,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0]            DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [ADDRESS_LEN-1:0] STEP_W  = ADDRESS_LEN'(PC_STEP);

    logic [ADDRESS_LEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic                       inflight_q, inflight_d;
    logic [ADDRESS_LEN-1:0]     inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [ADDRESS_LEN-1:0]     q_pc_q [DEPTH];
    logic [ADDRESS_LEN-1:0]     q_pc_d [DEPTH];
    logic [INSTRUCTION_LEN-1:0] q_instr_q [DEPTH];
    logic [INSTRUCTION_LEN-1:0] q_instr_d [DEPTH];

    logic        issue;
    logic        push;
    logic        pop;
    logic [CW:0] occupancy;

    // Handshake decisions and head-of-queue outputs.
    always_comb begin
        // The in-flight word already owns a slot, so a response can never overflow.
        occupancy         = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue             = !rst && !Branch_taken && (occupancy < DEPTH_W);
        push              = !rst && !Branch_taken && inflight_q;
        Instruction_valid = !rst && !Branch_taken && (count_q != '0);
        pop               = Instruction_valid && !freeze;
        imem_req          = issue;
        imem_addr         = fetch_pc_q;
        Instruction       = '0;
        PC                = '0;
        if (Instruction_valid) begin
            Instruction = q_instr_q[rd_ptr_q];
            PC          = q_pc_q[rd_ptr_q] + STEP_W;
        end
        queue_count = rst ? '0 : count_q;
    end

    // Next-state: fetch sequencing, queue push/pop and branch squash.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + STEP_W;
        end
        if (push) begin
            q_pc_d[wr_ptr_q]    = inflight_pc_q;
            q_instr_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        // A redirect drops everything queued; the in-flight word is lost because
        // inflight_d follows issue, which is low this cycle.
        if (Branch_taken) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            fetch_pc_d = BranchAddr;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; contents are only meaningful under count_q, so no reset.
    always_ff @(posedge clk) begin
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Testbench for if_prefetch_stage: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the fetch stage.
module tb_if_prefetch_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        Branch_taken = 1'b0;
    logic [31:0] BranchAddr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        Instruction_valid;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [2:0]  queue_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: fetch addresses queued, one outstanding request, next PC.
    logic [31:0] exp_q[$];
    logic        pend_v   = 1'b0;
    logic [31:0] pend_pc  = '0;
    logic [31:0] model_pc = '0;

    if_prefetch_stage #(
        .ADDRESS_LEN(32), .INSTRUCTION_LEN(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(Branch_taken),
        .BranchAddr(BranchAddr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .Instruction_valid(Instruction_valid),
        .Instruction(Instruction), .PC(PC), .queue_count(queue_count)
    );

    // Clock.
    always #5 clk = ~clk;

    // Instruction memory: addr^KEY one cycle after a request, garbage otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ KEY;
        else          imem_rdata <= $urandom;
    end

    // Drive one cycle of inputs, compare DUT outputs with the model, advance model.
    task automatic drive_cycle(input logic r, input logic b, input logic [31:0] ba, input logic f);
        logic        e_valid;
        logic        e_req;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        @(negedge clk);
        rst = r; Branch_taken = b; BranchAddr = ba; freeze = f;
        #1;
        cyc++;
        e_valid = !r && !b && (exp_q.size() != 0);
        e_req   = !r && !b && ((exp_q.size() + (pend_v ? 1 : 0)) < DEPTH);
        e_instr = e_valid ? (exp_q[0] ^ KEY) : 32'h0;
        e_pc    = e_valid ? (exp_q[0] + 32'd4) : 32'h0;
        e_cnt   = r ? 3'd0 : 3'(exp_q.size());
        n_checks++;
        if (Instruction_valid !== e_valid)
            $display("FAIL model_valid cyc=%0d got=%b exp=%b", cyc, Instruction_valid, e_valid);
        else n_pass++;
        n_checks++;
        if (imem_req !== e_req)
            $display("FAIL model_req cyc=%0d got=%b exp=%b", cyc, imem_req, e_req);
        else n_pass++;
        n_checks++;
        if (Instruction !== e_instr || PC !== e_pc)
            $display("FAIL model_head cyc=%0d got=%h/%h exp=%h/%h", cyc, Instruction, PC, e_instr, e_pc);
        else n_pass++;
        n_checks++;
        if (queue_count !== e_cnt)
            $display("FAIL model_count cyc=%0d got=%0d exp=%0d", cyc, queue_count, e_cnt);
        else n_pass++;
        if (!r) begin
            n_checks++;
            if (imem_addr !== model_pc)
                $display("FAIL model_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, model_pc);
            else n_pass++;
        end
        if (r) begin
            exp_q.delete(); pend_v = 1'b0; model_pc = 32'h0;
        end else if (b) begin
            exp_q.delete(); pend_v = 1'b0; model_pc = ba;
        end else begin
            if (e_valid && !f) void'(exp_q.pop_front());
            if (pend_v) exp_q.push_back(pend_pc);
            pend_v = e_req;
            if (e_req) begin
                pend_pc  = model_pc;
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b0 || Instruction_valid !== 1'b0 || Instruction !== 32'h0 ||
            PC !== 32'h0 || queue_count !== 3'd0)
            $display("FAIL reset_outputs got req=%b v=%b i=%h pc=%h cnt=%0d exp all 0",
                     imem_req, Instruction_valid, Instruction, PC, queue_count);
        else n_pass++;
    endtask

    task automatic test_stream();
        drive_cycle(0, 0, 0, 0);  // cycle 0
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL stream_first_req got %b/%h exp 1/00000000", imem_req, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // cycle 1
        n_checks++;
        if (Instruction_valid !== 1'b0 || imem_addr !== 32'h4)
            $display("FAIL stream_c1 got v=%b addr=%h exp v=0 addr=00000004", Instruction_valid, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // cycle 2
        n_checks++;
        if (Instruction_valid !== 1'b1 || Instruction !== 32'hA5A50000 || PC !== 32'h4)
            $display("FAIL stream_c2 got v=%b %h/%h exp 1 a5a50000/00000004", Instruction_valid, Instruction, PC);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // cycle 3
        n_checks++;
        if (Instruction_valid !== 1'b1 || Instruction !== 32'hA5A50004 || PC !== 32'h8)
            $display("FAIL stream_c3 got v=%b %h/%h exp 1 a5a50004/00000008", Instruction_valid, Instruction, PC);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(0, 0, 0, 0);
            n_checks++;
            if (Instruction_valid !== 1'b1 || PC !== 32'(12 + 4 * i))
                $display("FAIL stream_steady got v=%b pc=%h exp 1/%h", Instruction_valid, PC, 32'(12 + 4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_freeze_fill();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);  // cycle 0
        drive_cycle(0, 0, 0, 0);  // cycle 1
        for (int c = 2; c < 12; c++) begin
            drive_cycle(0, 0, 0, 1);
            if (c == 4) begin
                n_checks++;
                if (imem_req !== 1'b0)
                    $display("FAIL freeze_req_stop got %b exp 0", imem_req);
                else n_pass++;
            end
        end
        n_checks++;
        if (queue_count !== 3'd4 || PC !== 32'h4 || Instruction_valid !== 1'b1)
            $display("FAIL freeze_full got cnt=%0d pc=%h v=%b exp 4/00000004/1", queue_count, PC, Instruction_valid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 0, 0, 0);
            n_checks++;
            if (Instruction_valid !== 1'b1 || PC !== 32'(4 + 4 * i))
                $display("FAIL freeze_drain got v=%b pc=%h exp 1/%h", Instruction_valid, PC, 32'(4 + 4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_branch_squash();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 1, 32'h100, 0);  // t: count=3 with one in flight
        n_checks++;
        if (queue_count !== 3'd3 || Instruction_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL squash_t got cnt=%0d v=%b req=%b exp 3/0/0", queue_count, Instruction_valid, imem_req);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // t+1
        n_checks++;
        if (queue_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
            $display("FAIL squash_t1 got cnt=%0d req=%b addr=%h exp 0/1/00000100", queue_count, imem_req, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // t+2
        n_checks++;
        if (Instruction_valid !== 1'b0)
            $display("FAIL squash_t2 got v=%b exp 0", Instruction_valid);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);  // t+3
        n_checks++;
        if (Instruction_valid !== 1'b1 || PC !== 32'h104 || Instruction !== (32'h100 ^ KEY))
            $display("FAIL squash_t3 got v=%b %h/%h exp 1 %h/00000104", Instruction_valid, Instruction, PC, 32'h100 ^ KEY);
        else n_pass++;
    endtask

    task automatic test_branch_freeze();
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 1, 32'h2000, 1);
        n_checks++;
        if (queue_count !== 3'd4 || Instruction_valid !== 1'b0)
            $display("FAIL brfrz_t got cnt=%0d v=%b exp 4/0", queue_count, Instruction_valid);
        else n_pass++;
        drive_cycle(0, 0, 0, 1);
        n_checks++;
        if (queue_count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h2000)
            $display("FAIL brfrz_t1 got cnt=%0d req=%b addr=%h exp 0/1/00002000", queue_count, imem_req, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (Instruction_valid !== 1'b1 || PC !== 32'h2004)
            $display("FAIL brfrz_t3 got v=%b pc=%h exp 1/00002004", Instruction_valid, PC);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        drive_cycle(0, 1, 32'hFFFFFFFC, 0);
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC)
            $display("FAIL wrap_req0 got %b/%h exp 1/fffffffc", imem_req, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_req1 got %b/%h exp 1/00000000", imem_req, imem_addr);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (Instruction_valid !== 1'b1 || PC !== 32'h0 || Instruction !== 32'h5A5AFFFC)
            $display("FAIL wrap_out0 got v=%b %h/%h exp 1 5a5afffc/00000000", Instruction_valid, Instruction, PC);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (Instruction_valid !== 1'b1 || PC !== 32'h4)
            $display("FAIL wrap_out1 got v=%b pc=%h exp 1/00000004", Instruction_valid, PC);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive_cycle(0, 1, 32'h3000, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1);
        drive_cycle(1, 0, 0, 1);  // count=2 with one in flight
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (Instruction_valid !== 1'b0 || Instruction !== 32'h0 || PC !== 32'h0 ||
            queue_count !== 3'd0 || imem_addr !== 32'h0 || imem_req !== 1'b1)
            $display("FAIL midrst_after got v=%b i=%h pc=%h cnt=%0d addr=%h req=%b exp 0/0/0/0/00000000/1",
                     Instruction_valid, Instruction, PC, queue_count, imem_addr, imem_req);
        else n_pass++;
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        n_checks++;
        if (Instruction_valid !== 1'b1 || PC !== 32'h4 || Instruction !== KEY)
            $display("FAIL midrst_first got v=%b %h/%h exp 1 a5a50000/00000004", Instruction_valid, Instruction, PC);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] ba;
        for (int i = 0; i < 600; i++) begin
            ba = $urandom;
            ba = ba & 32'hFFFF_FFFC;
            drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0, ba,
                        $urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze_fill();
        test_branch_squash();
        test_branch_freeze();
        test_pc_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
